// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and display outputs of the MM:SS stopwatch controller.
// The pulse source owns the master side; the controller owns the slave side.
interface stopwatch_ctrl_if;
    logic       tick;
    logic       start_stop;
    logic       lap_clear;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       running;
    logic       lap_active;
    logic       overflow;

    modport master (
        output tick, start_stop, lap_clear,
        input  d0, d1, d2, d3, running, lap_active, overflow
    );

    modport slave (
        input  tick, start_stop, lap_clear,
        output d0, d1, d2, d3, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap controller for a four-digit BCD MM:SS stopwatch. It gates the 1 Hz tick
// into the digit cascade and freezes a lap snapshot on the display.
module stopwatch_ctrl #(
    parameter bit WRAP = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    stopwatch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t          state, state_next;
    logic [3:0][3:0] cnt, cnt_next;
    logic [3:0][3:0] lap, lap_next;
    logic [3:0][3:0] disp, disp_next;
    logic            ovf, ovf_next;
    logic            running, lap_active;
    logic            capture, clear, active, at_max, count_en, carry;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lap        <= '0;
            disp       <= '0;
            ovf        <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            lap        <= lap_next;
            disp       <= disp_next;
            ovf        <= ovf_next;
            running    <= (state_next == RUN) || (state_next == LAP);
            lap_active <= (state_next == LAP);
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE:  if (bus.start_stop) state_next = RUN;
            RUN: begin
                if (bus.start_stop) begin
                    state_next = PAUSE;
                end else if (bus.lap_clear) begin
                    state_next = LAP;
                    capture    = 1'b1;
                end
            end
            LAP: begin
                if (bus.start_stop)     state_next = PAUSE;
                else if (bus.lap_clear) state_next = RUN;
            end
            PAUSE: begin
                if (bus.start_stop) begin
                    state_next = RUN;
                end else if (bus.lap_clear) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Enable is decided from the registered state, so a tick on the resume edge is not counted
    // while a tick on the pause edge is. The whole carry chain settles in one cycle.
    always_comb begin
        active   = (state == RUN) || (state == LAP);
        at_max   = (cnt == {4'd5, 4'd9, 4'd5, 4'd9});
        count_en = bus.tick && active && !(!WRAP && at_max);
        carry    = count_en;
        cnt_next = cnt;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (cnt[i] == ((i[0] == 1'b0) ? 4'd9 : 4'd5)) cnt_next[i] = '0;
                else                                          cnt_next[i] = cnt[i] + 4'd1;
            end
            carry = carry && (cnt[i] == ((i[0] == 1'b0) ? 4'd9 : 4'd5));
        end
        if (clear) cnt_next = '0;

        ovf_next = ovf || (bus.tick && active && at_max);
        if (clear) ovf_next = 1'b0;

        lap_next = lap;
        if (capture)    lap_next = cnt_next;
        else if (clear) lap_next = '0;

        disp_next = (state_next == LAP) ? lap_next : cnt_next;
    end

    assign bus.d0         = disp[0];
    assign bus.d1         = disp[1];
    assign bus.d2         = disp[2];
    assign bus.d3         = disp[3];
    assign bus.running    = running;
    assign bus.lap_active = lap_active;
    assign bus.overflow   = ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a wrapping and a saturating instance share stimulus and are
// compared every cycle against a seconds-based reference model.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_ctrl_if bw();
    stopwatch_ctrl_if bs();

    stopwatch_ctrl #(.WRAP(1'b1)) dut_w (.clk(clk), .reset(reset), .bus(bw.slave));
    stopwatch_ctrl #(.WRAP(1'b0)) dut_s (.clk(clk), .reset(reset), .bus(bs.slave));

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model: index 0 = wrapping instance, 1 = saturating instance.
    typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE} mode_t;
    mode_t m_mode [2];
    int    m_secs [2];
    int    m_lap  [2];
    bit    m_ovf  [2];

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE;
            m_secs[i] = 0;
            m_lap[i]  = 0;
            m_ovf[i]  = 1'b0;
        end
    endtask

    task automatic model_step(bit t, bit ss, bit lc);
        for (int i = 0; i < 2; i++) begin
            if (t && (m_mode[i] == M_RUN || m_mode[i] == M_LAP)) begin
                if (m_secs[i] == 3599) begin
                    m_ovf[i] = 1'b1;
                    if (i == 0) m_secs[i] = 0;
                end else begin
                    m_secs[i]++;
                end
            end
            if (ss) begin
                case (m_mode[i])
                    M_IDLE, M_PAUSE: m_mode[i] = M_RUN;
                    default:         m_mode[i] = M_PAUSE;
                endcase
            end else if (lc) begin
                case (m_mode[i])
                    M_RUN: begin
                        m_mode[i] = M_LAP;
                        m_lap[i]  = m_secs[i];
                    end
                    M_LAP: m_mode[i] = M_RUN;
                    M_PAUSE: begin
                        m_mode[i] = M_IDLE;
                        m_secs[i] = 0;
                        m_lap[i]  = 0;
                        m_ovf[i]  = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_one(string tag, int i, logic [15:0] digits,
                               logic run, logic lapa, logic ovf);
        int shown;
        shown = (m_mode[i] == M_LAP) ? m_lap[i] : m_secs[i];
        check({tag, "_digits"}, digits, to_bcd(shown));
        check({tag, "_running"}, 16'(run), 16'(m_mode[i] == M_RUN || m_mode[i] == M_LAP));
        check({tag, "_lap"}, 16'(lapa), 16'(m_mode[i] == M_LAP));
        check({tag, "_ovf"}, 16'(ovf), 16'(m_ovf[i]));
    endtask

    task automatic compare_all();
        compare_one("wrap", 0, {bw.d3, bw.d2, bw.d1, bw.d0}, bw.running, bw.lap_active, bw.overflow);
        compare_one("sat", 1, {bs.d3, bs.d2, bs.d1, bs.d0}, bs.running, bs.lap_active, bs.overflow);
    endtask

    task automatic drive(bit t, bit ss, bit lc);
        bw.tick = t; bw.start_stop = ss; bw.lap_clear = lc;
        bs.tick = t; bs.start_stop = ss; bs.lap_clear = lc;
    endtask

    task automatic step(bit t, bit ss, bit lc);
        drive(t, ss, lc);
        @(posedge clk);
        model_step(t, ss, lc);
        #1;
        drive(1'b0, 1'b0, 1'b0);
        compare_all();
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset(bit t, bit ss, bit lc);
        reset = 1'b1;
        drive(t, ss, lc);
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        compare_all();
    endtask

    function automatic logic [15:0] wdig();
        return {bw.d3, bw.d2, bw.d1, bw.d0};
    endfunction

    function automatic logic [15:0] sdig();
        return {bs.d3, bs.d2, bs.d1, bs.d0};
    endfunction

    task automatic random_phase(int n);
        bit t, ss, lc;
        for (int k = 0; k < n; k++) begin
            t  = ($urandom % 3) == 0;
            ss = ($urandom % 16) == 0;
            lc = ($urandom % 12) == 0;
            if (($urandom % 500) == 0) do_reset(t, ss, lc);
            else                       step(t, ss, lc);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        do_reset(1'b0, 1'b0, 1'b0);

        // Start and count to 01:15
        step(1'b0, 1'b1, 1'b0);
        ticks(75);
        check("start_0115", wdig(), 16'h0115);
        check("start_running", 16'(bw.running), 16'h1);

        // Pause with coincident tick counts; resume with coincident tick does not
        step(1'b1, 1'b1, 1'b0);
        check("pause_tick", wdig(), 16'h0116);
        ticks(3);
        check("pause_hold", wdig(), 16'h0116);
        check("pause_running", 16'(bw.running), 16'h0);
        step(1'b1, 1'b1, 1'b0);
        check("resume_tick", wdig(), 16'h0116);
        step(1'b1, 1'b0, 1'b0);
        check("resume_count", wdig(), 16'h0117);

        // Lap freeze at 00:09
        do_reset(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        ticks(9);
        step(1'b0, 1'b0, 1'b1);
        check("lap_entry", wdig(), 16'h0009);
        check("lap_active", 16'(bw.lap_active), 16'h1);
        ticks(5);
        check("lap_frozen", wdig(), 16'h0009);
        step(1'b0, 1'b0, 1'b1);
        check("lap_exit", wdig(), 16'h0014);

        // Simultaneous buttons: start_stop wins
        step(1'b0, 1'b1, 1'b1);
        check("both_run_lap", 16'(bw.lap_active), 16'h0);
        check("both_run_paused", 16'(bw.running), 16'h0);
        step(1'b0, 1'b1, 1'b1);
        check("both_pause_run", 16'(bw.running), 16'h1);
        check("both_pause_kept", wdig(), 16'h0014);

        // Wrap vs saturate at 59:59
        do_reset(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        ticks(3599);
        check("max_wrap", wdig(), 16'h5959);
        check("max_sat", sdig(), 16'h5959);
        check("max_no_ovf", 16'(bw.overflow), 16'h0);
        ticks(1);
        check("wrap_zero", wdig(), 16'h0000);
        check("wrap_ovf", 16'(bw.overflow), 16'h1);
        check("sat_hold", sdig(), 16'h5959);
        check("sat_ovf", 16'(bs.overflow), 16'h1);
        ticks(3);
        check("wrap_after", wdig(), 16'h0003);
        check("sat_after", sdig(), 16'h5959);
        check("sat_running", 16'(bs.running), 16'h1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("clear_wrap", wdig(), 16'h0000);
        check("clear_sat", sdig(), 16'h0000);
        check("clear_ovf", 16'(bs.overflow), 16'h0);
        check("clear_idle", 16'(bs.running), 16'h0);

        // Reset mid-lap at 12:34
        step(1'b0, 1'b1, 1'b0);
        ticks(754);
        step(1'b0, 1'b0, 1'b1);
        check("midlap_capture", wdig(), 16'h1234);
        ticks(10);
        do_reset(1'b1, 1'b1, 1'b1);
        check("midlap_reset_d", wdig(), 16'h0000);
        check("midlap_reset_lap", 16'(bw.lap_active), 16'h0);

        // Random traffic, once from zero and once near the 59:59 boundary
        random_phase(3000);
        do_reset(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        ticks(3590);
        random_phase(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
